// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum byte is enabled by defining BOOT_CHECKSUM_EN.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERR
    } boot_state_t;

    localparam logic [7:0] BOOT_MAGIC = 8'hA5;

    typedef logic [15:0] word_cnt_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and boot status of the loader.
// Handshake: a byte moves on a rising edge where in_valid && in_ready; in_data must be
// held stable while in_valid is high and in_ready is low.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              boot_done;
    logic              boot_err;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, boot_done, boot_err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, boot_done, boot_err
    );

endinterface

// File: rtl/imem_boot_loader_word_asm.sv
// Little-endian byte-to-word assembler: three bytes are shifted in, the fourth completes
// the word combinationally together with a one-cycle word_valid.
module boot_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            shreg    <= 24'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            // Earlier bytes drift toward bit 0, so after three bytes shreg = {b2, b1, b0}.
            shreg    <= {byte_data, shreg[23:8]};
        end
    end

    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word       = {byte_data, shreg};

endmodule

// File: rtl/imem_boot_loader.sv
// Framed-image boot loader: parses A5 / N / payload [/ checksum], writes IMEM and holds the
// CPU in reset until the image is verified. BOOT_CHECKSUM_EN adds the trailing checksum byte.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus,
    output boot_state_t         dbg_state
);

    localparam logic [16:0] DEPTH_LIMIT = 17'(IMEM_DEPTH);

    boot_state_t       state;
    word_cnt_t         len;
    word_cnt_t         word_idx;
    word_cnt_t         len_full;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              cpu_rst_n_q;
    logic              boot_done_q;
    logic              boot_err_q;
    logic              accept;
    logic              word_valid;
    logic [31:0]       word;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    // No byte is taken in the write cycle, which keeps the assembler and FSM in lockstep.
    assign bus.in_ready = (state != DONE) && (state != ERR) && !imem_we_q;
    assign accept       = bus.in_valid && bus.in_ready;
    assign len_full     = {bus.in_data, len[7:0]};

    boot_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len          <= '0;
            word_idx     <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            boot_done_q  <= 1'b0;
            boot_err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum          <= 8'd0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && (bus.in_data == BOOT_MAGIC)) state <= LEN_LO;
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= bus.in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= bus.in_data;
                        if ({1'b0, len_full} > DEPTH_LIMIT) begin
                            state      <= ERR;
                            boot_err_q <= 1'b1;
                        end else if (len_full == '0) begin
`ifdef BOOT_CHECKSUM_EN
                            state       <= CHECK;
`else
                            state       <= DONE;
                            boot_done_q <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
`ifdef BOOT_CHECKSUM_EN
                    if (accept) sum <= sum + bus.in_data;
`endif
                    if (word_valid) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= word_idx[ADDR_W-1:0];
                        imem_wdata_q <= word;
                        word_idx     <= word_idx + 16'd1;
                    end
                    // Leave only in the write cycle of the last word, i.e. on the edge that
                    // commits it, so DONE can never precede a complete image.
                    if (imem_we_q && (word_idx == len)) begin
`ifdef BOOT_CHECKSUM_EN
                        state       <= CHECK;
`else
                        state       <= DONE;
                        boot_done_q <= 1'b1;
                        cpu_rst_n_q <= 1'b1;
`endif
                    end
                end
                CHECK: begin
`ifdef BOOT_CHECKSUM_EN
                    if (accept) begin
                        if (bus.in_data == sum) begin
                            state       <= DONE;
                            boot_done_q <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else begin
                            state      <= ERR;
                            boot_err_q <= 1'b1;
                        end
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE, ERR: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_rst_n  = cpu_rst_n_q;
    assign bus.boot_done  = boot_done_q;
    assign bus.boot_err   = boot_err_q;
    assign dbg_state      = state;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream program loader that sits directly upstream of the single-cycle CPU core. It accepts a framed binary image, writes it word-by-word into instruction memory and holds the CPU in reset until the image is fully and correctly loaded. On success it releases `cpu_rst_n`. On any framing or checksum fault it latches an error and keeps the CPU in reset.

## Interface
Parameters:
- `IMEM_DEPTH`, default 256: instruction memory depth in 32-bit words.
- `ADDR_W`, default `$clog2(IMEM_DEPTH)`: word-address width.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: byte-stream valid.
- `in_data` in 8: byte-stream data.
- `in_ready` out 1: loader can accept a byte. A byte transfers on a rising edge where `in_valid && in_ready`.
- `imem_we` out 1: instruction-memory write enable, one-cycle pulse.
- `imem_addr` out ADDR_W: word address of the write.
- `imem_wdata` out 32: word to write.
- `cpu_rst_n` out 1: active-low reset to the CPU core.
- `boot_done` out 1: image loaded and verified. Sticky.
- `boot_err` out 1: load failed. Sticky.

## Operation
- Frame format:
  - Magic byte `0xA5`.
  - Word count N as a 16-bit little-endian value.
  - N×4 payload bytes, each word little-endian (first byte is bits 7:0).
  - Checksum byte (only when the checksum feature is compiled in).
- FSM states:
  - IDLE: accepts bytes. Any byte other than `0xA5` is discarded and the FSM stays in IDLE. `0xA5` moves to LEN_LO.
  - LEN_LO: stores N[7:0], moves to LEN_HI.
  - LEN_HI: stores N[15:8].
    - If N > IMEM_DEPTH, go to ERR.
    - If N == 0, go to CHECK (or to DONE when the checksum feature is out).
    - Otherwise go to DATA.
  - DATA: a 2-bit byte counter assembles each word. On the 4th byte, a write issues at the current word address and the address increments. After the N-th word, go to CHECK (or DONE).
  - CHECK: the next byte is compared with the running sum. Equal goes to DONE, otherwise to ERR.
  - DONE and ERR: terminal until `rst`. All further input bytes are ignored.
- Checksum: 8-bit sum modulo 256 of all payload bytes only (header excluded). It is 0 when N == 0.
- Word address starts at 0 on every load and covers 0..N-1. It never wraps, because N ≤ IMEM_DEPTH is enforced.
- `in_ready`:
  - 1 in IDLE, LEN_LO, LEN_HI, DATA and CHECK.
  - 0 in DONE and ERR, and while `imem_we` is high.
- Reset mid-operation: returns to IDLE and clears the counters, address and checksum. `cpu_rst_n` goes low. Memory already written is not cleared.

## Timing
- Reset values:
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_rst_n` = 0, `boot_done` = 0, `boot_err` = 0.
  - `in_ready` = 1 (IDLE).
- Write latency: the 4th byte of a word is accepted at edge k. `imem_we`, `imem_addr` and `imem_wdata` are registered and high/valid during cycle k→k+1. Memory captures at edge k+1.
- Back-to-back throughput: one byte every cycle, except the cycle of each write, where `in_ready` = 0. That gives 5 cycles per word.
- DONE entry: `boot_done` and `cpu_rst_n` rise on the same edge that enters DONE. This is never earlier than the edge that commits the last write, so the CPU's first active edge sees a complete image.
- ERR entry: `boot_err` rises on the ERR entry edge. `cpu_rst_n` stays 0.
- Gaps in `in_valid` only stall the loader. No timeout.

## Configuration
- `BOOT_CHECKSUM_EN` defined: the CHECK state and checksum byte are present, with a mismatch going to ERR.
- `BOOT_CHECKSUM_EN` undefined: no checksum byte is expected. After the last word, or when N == 0, the FSM goes straight to DONE. The summing logic is removed.

## Structure
- Package `boot_pkg` holds:
  - The `boot_state_t` enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR).
  - `BOOT_MAGIC = 8'hA5`.
  - The 16-bit word-count type.
- One sub-module, `boot_word_asm`: byte-to-word little-endian shift register with a 2-bit byte counter and a `word_valid` output. It is cleared by `rst`.
- The top level holds the FSM, address counter, checksum and output registers.

## Test plan
- Nominal load with checksum: A5 02 00 93 00 50 00 13 00 00 00 F6. Expect writes addr0=0x00500093 and addr1=0x00000013, then `boot_done`=1 and `cpu_rst_n`=1, with `boot_err`=0.
- Bad checksum: same stream ending F7. Expect both writes, then `boot_err`=1, `cpu_rst_n`=0 and `in_ready`=0.
- Oversize: A5 01 01 (N=257, IMEM_DEPTH=256). Expect ERR after the 3rd byte, with no `imem_we` pulse.
- Garbage and gaps: bytes 00 FF 5A precede the nominal frame, and `in_valid` is deasserted randomly. Expect results identical to the nominal load.
- Reset mid-DATA: `rst` is pulsed after 5 payload bytes, then the nominal frame is resent. Expect the first write to be at addr0 with correct data, and `boot_done`=1.
- Empty image: A5 00 00 00. Expect no writes and `boot_done`=1. Without `BOOT_CHECKSUM_EN`, A5 00 00 alone gives DONE.
